// File: rtl/brightness_distortion_gen.sv
// brightness_distortion_gen: Q16.16 alpha = sum(I*E) / sum(E^2) via a sequential restoring divider.
// Define BD_DIV_RADIX4_EN to retire two quotient bits per DIV cycle instead of one.
module brightness_distortion_gen #(
   parameter int FRAC_BITS = 16,
   parameter int DIV_BITS  = 42
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_I_R,
   input  logic [7:0]         in_I_G,
   input  logic [7:0]         in_I_B,
   input  logic [15:0]        in_E_R,
   input  logic [15:0]        in_E_G,
   input  logic [15:0]        in_E_B,
   output logic [7:0]         I_R,
   output logic [7:0]         I_G,
   output logic [7:0]         I_B,
   output logic [15:0]        E_R,
   output logic [15:0]        E_G,
   output logic [15:0]        E_B,
   output logic signed [31:0] alpha,
   output logic               valid_out,
   output logic               zero_den
);
   localparam logic [1:0] S_IDLE = 2'd0, S_MAC = 2'd1, S_DIV = 2'd2, S_OUT = 2'd3;
   localparam int NW = DIV_BITS - FRAC_BITS;
   localparam int DW = 34;
   localparam int RW = DW + 1;
`ifdef BD_DIV_RADIX4_EN
   localparam int STEPS = 2;
`else
   localparam int STEPS = 1;
`endif
   localparam logic [5:0] LAST = 6'(DIV_BITS / STEPS - 1);

   logic [1:0]          state_q, state_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [23:0]         hi_q, hi_d, oi_q, oi_d;
   logic [47:0]         he_q, he_d, oe_q, oe_d;
   logic [DW-1:0]       den_q, den_d, d_sum;
   logic [RW-1:0]       rem_q, rem_d, r;
   logic [DIV_BITS-1:0] dvd_q, dvd_d, dv, quo_q, quo_d, qt;
   logic [31:0]         alpha_q, alpha_d;
   logic                zd_q, zd_d, vld_q, vld_d, ge;
   logic [NW-1:0]       n_sum;

   assign n_sum = NW'(hi_q[23:16]) * NW'(he_q[47:32]) + NW'(hi_q[15:8]) * NW'(he_q[31:16])
                + NW'(hi_q[7:0]) * NW'(he_q[15:0]);
   assign d_sum = DW'(he_q[47:32]) * DW'(he_q[47:32]) + DW'(he_q[31:16]) * DW'(he_q[31:16])
                + DW'(he_q[15:0]) * DW'(he_q[15:0]);

   // Remainder stays below den before each shift, so one extra bit suffices.
   always_comb begin
      r  = rem_q;
      dv = dvd_q;
      qt = quo_q;
      ge = 1'b0;
      for (int s = 0; s < STEPS; s++) begin
         r  = {r[DW-1:0], dv[DIV_BITS-1]};
         dv = dv << 1;
         ge = r >= {1'b0, den_q};
         r  = ge ? r - {1'b0, den_q} : r;
         qt = {qt[DIV_BITS-2:0], ge};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      he_d    = he_q;
      oi_d    = oi_q;
      oe_d    = oe_q;
      den_d   = den_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      quo_d   = quo_q;
      alpha_d = alpha_q;
      zd_d    = zd_q;
      vld_d   = 1'b0;
      case (state_q)
         S_IDLE: if (in_valid) begin
            hi_d    = {in_I_R, in_I_G, in_I_B};
            he_d    = {in_E_R, in_E_G, in_E_B};
            state_d = S_MAC;
         end
         S_MAC: begin
            den_d   = d_sum;
            dvd_d   = DIV_BITS'(n_sum) << FRAC_BITS;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = (d_sum == '0) ? S_OUT : S_DIV;
         end
         S_DIV: begin
            rem_d   = r;
            dvd_d   = dv;
            quo_d   = qt;
            cnt_d   = cnt_q + 6'd1;
            state_d = (cnt_q == LAST) ? S_OUT : S_DIV;
         end
         default: begin
            alpha_d = quo_q[31:0];
            oi_d    = hi_q;
            oe_d    = he_q;
            zd_d    = den_q == '0;
            vld_d   = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         he_q    <= '0;
         oi_q    <= '0;
         oe_q    <= '0;
         den_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         alpha_q <= '0;
         zd_q    <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         he_q    <= he_d;
         oi_q    <= oi_d;
         oe_q    <= oe_d;
         den_q   <= den_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         quo_q   <= quo_d;
         alpha_q <= alpha_d;
         zd_q    <= zd_d;
         vld_q   <= vld_d;
      end
   end

   assign in_ready          = (state_q == S_IDLE) && !rst;
   assign {I_R, I_G, I_B}   = oi_q;
   assign {E_R, E_G, E_B}   = oe_q;
   assign alpha             = alpha_q;
   assign zero_den          = zd_q;
   assign valid_out         = vld_q;
endmodule

// File: tb/tb_brightness_distortion_gen.sv
// tb_brightness_distortion_gen: directed vectors checked against an arithmetic model of alpha and timing.
module tb_brightness_distortion_gen;
`ifdef BD_DIV_RADIX4_EN
   localparam int LAT = 23;
`else
   localparam int LAT = 44;
`endif
   logic clk = 0, rst = 1, in_valid = 1;
   logic [7:0] in_I_R = 8'd5, in_I_G = 8'd6, in_I_B = 8'd7;
   logic [15:0] in_E_R = 16'd1, in_E_G = 16'd2, in_E_B = 16'd3;
   logic [7:0] I_R, I_G, I_B;
   logic [15:0] E_R, E_G, E_B;
   logic signed [31:0] alpha;
   logic valid_out, zero_den, in_ready;

   brightness_distortion_gen dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_I_R(in_I_R), .in_I_G(in_I_G), .in_I_B(in_I_B),
      .in_E_R(in_E_R), .in_E_G(in_E_G), .in_E_B(in_E_B),
      .I_R(I_R), .I_G(I_G), .I_B(I_B), .E_R(E_R), .E_G(E_G), .E_B(E_B),
      .alpha(alpha), .valid_out(valid_out), .zero_den(zero_den));

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] i;
      logic [47:0] e;
      logic [31:0] alpha;
      logic        zd;
      int          acc;
      int          lat;
      logic [31:0] lit;
      bit          has_lit;
   } exp_t;

   exp_t q[$];
   exp_t hold = '{default: 0};
   int cyc = 0, vec = 0, err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [23:0] i, input logic [47:0] e);
      exp_t m = '{default: 0};
      longint n, d;
      n = longint'(i[23:16]) * longint'(e[47:32]) + longint'(i[15:8]) * longint'(e[31:16])
        + longint'(i[7:0]) * longint'(e[15:0]);
      d = longint'(e[47:32]) * longint'(e[47:32]) + longint'(e[31:16]) * longint'(e[31:16])
        + longint'(e[15:0]) * longint'(e[15:0]);
      m.i = i;
      m.e = e;
      m.zd = (d == 0);
      m.alpha = (d == 0) ? 32'd0 : 32'((n << 16) / d);
      m.lat = (d == 0) ? 2 : LAT;
      return m;
   endfunction

   // Every cycle: valid_out timing, in_ready, and held outputs against the model.
   initial forever begin
      logic vexp;
      @(negedge clk);
      #1;
      vexp = q.size() > 0 && cyc == q[0].acc + q[0].lat;
      chk("valid_out", valid_out, vexp);
      if (vexp) begin
         hold = q.pop_front();
         if (hold.has_lit) chk("alpha_literal", $unsigned(alpha), hold.lit);
      end
      chk("in_ready", in_ready, !rst && q.size() == 0);
      chk("alpha", $unsigned(alpha), hold.alpha);
      chk("zero_den", zero_den, hold.zd);
      chk("I_out", {I_R, I_G, I_B}, hold.i);
      chk("E_out", {E_R, E_G, E_B}, hold.e);
      if (rst) begin
         q.delete();
         hold = '{default: 0};
      end
   end

   task automatic send(input logic [23:0] i, input logic [47:0] e, input logic [31:0] lit,
                       input bit has_lit, output int acc);
      exp_t m;
      int t = 0;
      {in_I_R, in_I_G, in_I_B} = i;
      {in_E_R, in_E_G, in_E_B} = e;
      in_valid = 1;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      acc = -1;
      if (!in_ready) begin
         vec++;
         err++;
         $display("FAIL accept_timeout: in_ready still %b after %0d cycles, expected 1", in_ready, t);
      end else begin
         @(posedge clk);
         #1;
         m = model(i, e);
         m.acc = cyc;
         m.lit = lit;
         m.has_lit = has_lit;
         q.push_back(m);
         acc = cyc;
      end
      @(negedge clk);
      in_valid = 0;
   endtask

   initial begin
      int a1, a2, t;
      repeat (3) @(negedge clk);
      rst = 0;
      in_valid = 0;
      @(negedge clk);
      send({8'd100, 8'd100, 8'd100}, {16'd100, 16'd100, 16'd100}, 32'h0001_0000, 1, a1);
      send({8'd50, 8'd50, 8'd50}, {16'd100, 16'd100, 16'd100}, 32'h0000_8000, 1, a1);
      repeat (60) @(negedge clk);
      send({8'd255, 8'd0, 8'd0}, {16'd1, 16'd0, 16'd0}, 32'h00FF_0000, 1, a1);
      send({8'd7, 8'd8, 8'd9}, {16'd0, 16'd0, 16'd0}, 32'h0, 1, a1);
      repeat (5) @(negedge clk);
      send({8'd255, 8'd255, 8'd255}, {16'd1, 16'd1, 16'd1}, 32'h00FF_0000, 1, a1);
      send({8'd200, 8'd10, 8'd30}, {16'd300, 16'd40000, 16'd5}, 32'h0, 0, a1);
      send({8'd1, 8'd2, 8'd3}, {16'd65535, 16'd65535, 16'd65535}, 32'h0, 0, a2);
      chk("accept_spacing", 64'(a2 - a1), 64'(LAT + 1));
      send({8'd9, 8'd9, 8'd9}, {16'd3, 16'd3, 16'd3}, 32'h0003_0000, 0, a1);
      while (cyc < a1 + 21) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      repeat (2) @(negedge clk);
      send({8'd10, 8'd20, 8'd30}, {16'd40, 16'd50, 16'd60}, 32'h0, 0, a1);
      send({8'd3, 8'd4, 8'd0}, {16'd6, 16'd8, 16'd0}, 32'h0000_8000, 1, a1);
      t = 0;
      while (q.size() > 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (q.size() > 0) begin
         vec++;
         err++;
         $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
      end
      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
